// File: rtl/fft_sched_pkg.sv
// Shared types and helpers for the radix-2 DIF FFT butterfly scheduler.
// Used by fft_dif_sched; optional bit-reversed readout is enabled with FFT_SCHED_BITREV_EN.
package fft_sched_pkg;

    localparam int unsigned MAX_AW = 12;
    localparam int unsigned IW     = $clog2(MAX_AW);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        RDOUT,
        DONE
    } sched_state_e;

    // Write-back distance from read strobe to RAM write
    function automatic int unsigned sched_delay(input int unsigned rd_lat,
                                                input int unsigned bf_lat);
        return rd_lat + bf_lat;
    endfunction

    function automatic int unsigned stage_w(input int unsigned log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

    function automatic logic [MAX_AW-1:0] bfly_span(input int unsigned s,
                                                    input int unsigned log2n);
        return MAX_AW'(1) << (log2n - 1 - s);
    endfunction

    // Upper-leg address: group base (g * 2 * span) plus offset j inside the group
    function automatic logic [MAX_AW-1:0] bfly_addr_a(input logic [MAX_AW-1:0] k,
                                                      input int unsigned s,
                                                      input int unsigned log2n);
        logic [MAX_AW-1:0] span;
        logic [MAX_AW-1:0] j;
        logic [MAX_AW-1:0] g;
        span = bfly_span(s, log2n);
        j    = k & (span - MAX_AW'(1));
        g    = k >> (log2n - 1 - s);
        return (g << (log2n - s)) | j;
    endfunction

    function automatic logic [MAX_AW-1:0] bfly_tw(input logic [MAX_AW-1:0] k,
                                                  input int unsigned s,
                                                  input int unsigned log2n);
        logic [MAX_AW-1:0] span;
        span = bfly_span(s, log2n);
        return (k & (span - MAX_AW'(1))) << s;
    endfunction

    function automatic logic [MAX_AW-1:0] bit_rev(input logic [MAX_AW-1:0] n,
                                                  input int unsigned log2n);
        logic [MAX_AW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_AW; i++) begin
            if (i < log2n) begin
                r[IW'(log2n - 1 - i)] = n[IW'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register carrying {valid, addr_a, addr_b} from read to write-back.
// pend_c flags a valid entry still in flight ahead of the output stage.
module fft_addr_delay #(
    parameter int unsigned W     = 9,
    parameter int unsigned DEPTH = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         pend_c
);

    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

    always_comb begin
        pend_c = 1'b0;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            pend_c = pend_c | sr[i][W-1];
        end
    end

endmodule

// File: rtl/fft_dif_sched.sv
// In-place single-butterfly scheduler for an N-point radix-2 DIF FFT.
// Define FFT_SCHED_BITREV_EN to add the bit-reversed readout phase and its ports.
module fft_dif_sched
    import fft_sched_pkg::*;
#(
    parameter int unsigned LOG2N  = 4,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BF_LAT = 5,
    parameter int unsigned AW     = LOG2N
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [stage_w(LOG2N)-1:0]    stage_o,
    output logic                         rd_en_o,
    output logic [AW-1:0]                rd_addr_a_o,
    output logic [AW-1:0]                rd_addr_b_o,
    output logic [LOG2N-2:0]             tw_addr_o,
    output logic                         bf_en_o,
    input  logic                         bf_valid_i,
    output logic                         wr_en_o,
    output logic [AW-1:0]                wr_addr_a_o,
    output logic [AW-1:0]                wr_addr_b_o,
`ifdef FFT_SCHED_BITREV_EN
    input  logic                         rdout_req_i,
    output logic [AW-1:0]                rdout_addr_o,
    output logic                         rdout_vld_o,
`endif
    output logic                         err_o
);

    localparam int unsigned N  = 1 << LOG2N;
    localparam int unsigned KW = LOG2N - 1;
    localparam int unsigned SW = stage_w(LOG2N);
    localparam int unsigned D  = sched_delay(RD_LAT, BF_LAT);
    localparam int unsigned DW = 2 * AW + 1;

    sched_state_e      state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [KW-1:0]     k_q, k_d;
    logic              err_clr;
    logic              drain_done;
    logic [AW-1:0]     addr_a_d, addr_b_d;
    logic [KW-1:0]     tw_d;
    logic [DW-1:0]     dly_out;
    logic              pend_c;
    logic [RD_LAT-1:0] bf_sr;
`ifdef FFT_SCHED_BITREV_EN
    logic [AW-1:0]     n_q, n_d;
`endif

    fft_addr_delay #(
        .W     (DW),
        .DEPTH (D)
    ) u_dly (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din    ({rd_en_o, rd_addr_a_o, rd_addr_b_o}),
        .dout   (dly_out),
        .pend_c (pend_c)
    );

    assign {wr_en_o, wr_addr_a_o, wr_addr_b_o} = dly_out;

    // Last write of the stage is on the RAM port and nothing else is in flight
    assign drain_done = wr_en_o & ~pend_c;

    // Next-state and next-address logic
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        err_clr = 1'b0;
`ifdef FFT_SCHED_BITREV_EN
        n_d     = n_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    s_d     = '0;
                    k_d     = '0;
                    err_clr = 1'b1;
                end
            end
            RUN: begin
                if (k_q == KW'(N / 2 - 1)) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    if (s_q == SW'(LOG2N - 1)) begin
`ifdef FFT_SCHED_BITREV_EN
                        state_d = RDOUT;
                        n_d     = '0;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + SW'(1);
                        k_d     = '0;
                    end
                end
            end
`ifdef FFT_SCHED_BITREV_EN
            RDOUT: begin
                if (rdout_req_i) begin
                    n_d = n_q + AW'(1);
                    if (n_q == AW'(N - 1)) begin
                        state_d = DONE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        addr_a_d = AW'(bfly_addr_a(MAX_AW'(k_d), 32'(s_d), LOG2N));
        addr_b_d = addr_a_d + AW'(bfly_span(32'(s_d), LOG2N));
        tw_d     = KW'(bfly_tw(MAX_AW'(k_d), 32'(s_d), LOG2N));
    end

    // State and registered outputs, driven from next-state values
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            s_q         <= '0;
            k_q         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            stage_o     <= '0;
            rd_en_o     <= 1'b0;
            rd_addr_a_o <= '0;
            rd_addr_b_o <= '0;
            tw_addr_o   <= '0;
            bf_sr       <= '0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            k_q         <= k_d;
            busy_o      <= (state_d == RUN) || (state_d == DRAIN) || (state_d == RDOUT);
            done_o      <= (state_d == DONE);
            stage_o     <= s_d;
            rd_en_o     <= (state_d == RUN);
            rd_addr_a_o <= (state_d == RUN) ? addr_a_d : '0;
            rd_addr_b_o <= (state_d == RUN) ? addr_b_d : '0;
            tw_addr_o   <= (state_d == RUN) ? tw_d : '0;
            bf_sr[0]    <= rd_en_o;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                bf_sr[i] <= bf_sr[i-1];
            end
            err_o       <= err_clr ? 1'b0 : (err_o | (bf_valid_i ^ wr_en_o));
        end
    end

    assign bf_en_o = bf_sr[RD_LAT-1];

`ifdef FFT_SCHED_BITREV_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_q          <= '0;
            rdout_vld_o  <= 1'b0;
            rdout_addr_o <= '0;
        end else begin
            n_q          <= n_d;
            rdout_vld_o  <= (state_q == RDOUT) && rdout_req_i;
            rdout_addr_o <= ((state_q == RDOUT) && rdout_req_i)
                            ? AW'(bit_rev(MAX_AW'(n_q), LOG2N)) : '0;
        end
    end
`endif

endmodule

// File: tb/tb_fft_dif_sched.sv
// Directed bench for fft_dif_sched (LOG2N=4, RD_LAT=1, BF_LAT=5) with a model butterfly.
module tb_fft_dif_sched;

    localparam int unsigned LOG2N  = 4;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned BF_LAT = 5;
    localparam int unsigned AW     = 4;

    logic          clk_i;
    logic          rst_i;
    logic          start_i;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    stage_o;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_a_o;
    logic [AW-1:0] rd_addr_b_o;
    logic [2:0]    tw_addr_o;
    logic          bf_en_o;
    logic          bf_valid_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_a_o;
    logic [AW-1:0] wr_addr_b_o;
    logic          err_o;

    logic [BF_LAT-1:0] bf_pipe;
    logic              supp;

    int n_chk;
    int n_fail;

    fft_dif_sched #(
        .LOG2N  (LOG2N),
        .RD_LAT (RD_LAT),
        .BF_LAT (BF_LAT),
        .AW     (AW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .stage_o     (stage_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_a_o (rd_addr_a_o),
        .rd_addr_b_o (rd_addr_b_o),
        .tw_addr_o   (tw_addr_o),
        .bf_en_o     (bf_en_o),
        .bf_valid_i  (bf_valid_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_a_o (wr_addr_a_o),
        .wr_addr_b_o (wr_addr_b_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Model butterfly: valid follows en after BF_LAT cycles, flushed by reset
    always @(posedge clk_i) begin
        if (rst_i) bf_pipe <= '0;
        else       bf_pipe <= {bf_pipe[BF_LAT-2:0], bf_en_o};
    end
    assign bf_valid_i = bf_pipe[BF_LAT-1] & ~supp;

    // Read strobe expected in cycle c after start in cycle 0: 8 reads every 14 cycles
    function automatic bit exp_rd(input int c);
        return (c >= 1) && (c <= 50) && (((c - 1) % 14) < 8);
    endfunction

    // Butterfly addresses for the read issued in cycle c
    function automatic void exp_addr(input int c, output int a, output int b,
                                     output int tw, output int s);
        int k;
        int span;
        s    = (c - 1) / 14;
        k    = (c - 1) % 14;
        span = 8 / (1 << s);
        a    = (k / span) * 2 * span + (k % span);
        b    = a + span;
        tw   = (k % span) * (1 << s);
    endfunction

    task automatic test_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        n_chk++;
        if ({busy_o, done_o, rd_en_o, bf_en_o, wr_en_o, err_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {busy_o, done_o, rd_en_o, bf_en_o, wr_en_o, err_o});
        end
        n_chk++;
        if ({stage_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_addr got stage=%0d ra=%0d rb=%0d tw=%0d wa=%0d wb=%0d want all 0",
                     stage_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o);
        end
    endtask

    task automatic test_schedule();
        int a, b, tw, s;
        int ha, hb, ht;
        bit hand;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            n_chk++;
            if (rd_en_o !== exp_rd(c)) begin
                n_fail++;
                $display("FAIL sched_rd_en c=%0d got %b want %b", c, rd_en_o, exp_rd(c));
            end
            n_chk++;
            if (wr_en_o !== exp_rd(c - 6)) begin
                n_fail++;
                $display("FAIL sched_wr_en c=%0d got %b want %b", c, wr_en_o, exp_rd(c - 6));
            end
            n_chk++;
            if (done_o !== (c == 57) || busy_o !== (c <= 56)) begin
                n_fail++;
                $display("FAIL sched_done_busy c=%0d got done=%b busy=%b want done=%b busy=%b",
                         c, done_o, busy_o, c == 57, c <= 56);
            end
            if (exp_rd(c)) begin
                exp_addr(c, a, b, tw, s);
                n_chk++;
                if (int'(rd_addr_a_o) !== a || int'(rd_addr_b_o) !== b ||
                    int'(tw_addr_o) !== tw || int'(stage_o) !== s) begin
                    n_fail++;
                    $display("FAIL sched_rd_addr c=%0d got a=%0d b=%0d tw=%0d s=%0d want a=%0d b=%0d tw=%0d s=%0d",
                             c, rd_addr_a_o, rd_addr_b_o, tw_addr_o, stage_o, a, b, tw, s);
                end
            end
            if (exp_rd(c - 6)) begin
                exp_addr(c - 6, a, b, tw, s);
                n_chk++;
                if (int'(wr_addr_a_o) !== a || int'(wr_addr_b_o) !== b) begin
                    n_fail++;
                    $display("FAIL sched_wr_addr c=%0d got a=%0d b=%0d want a=%0d b=%0d",
                             c, wr_addr_a_o, wr_addr_b_o, a, b);
                end
            end
            hand = 1'b1;
            ha = 0; hb = 0; ht = 0;
            case (c)
                1:  begin ha = 0; hb = 8;  ht = 0; end
                8:  begin ha = 7; hb = 15; ht = 7; end
                19: begin ha = 8; hb = 12; ht = 0; end
                20: begin ha = 9; hb = 13; ht = 2; end
                46: begin ha = 6; hb = 7;  ht = 0; end
                default: hand = 1'b0;
            endcase
            if (hand) begin
                n_chk++;
                if (int'(rd_addr_a_o) !== ha || int'(rd_addr_b_o) !== hb || int'(tw_addr_o) !== ht) begin
                    n_fail++;
                    $display("FAIL vector_rd c=%0d got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d",
                             c, rd_addr_a_o, rd_addr_b_o, tw_addr_o, ha, hb, ht);
                end
            end
            hand = 1'b1;
            case (c)
                7:  begin ha = 0; hb = 8;  end
                14: begin ha = 7; hb = 15; end
                25: begin ha = 8; hb = 12; end
                26: begin ha = 9; hb = 13; end
                52: begin ha = 6; hb = 7;  end
                default: hand = 1'b0;
            endcase
            if (hand) begin
                n_chk++;
                if (wr_en_o !== 1'b1 || int'(wr_addr_a_o) !== ha || int'(wr_addr_b_o) !== hb) begin
                    n_fail++;
                    $display("FAIL vector_wr c=%0d got en=%b a=%0d b=%0d want en=1 a=%0d b=%0d",
                             c, wr_en_o, wr_addr_a_o, wr_addr_b_o, ha, hb);
                end
            end
        end
        n_chk++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sched_err got %b want 0", err_o);
        end
    endtask

    task automatic test_start_ignored();
        @(posedge clk_i); #1;
        start_i = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk_i); #1;
            start_i = (c == 20);
            n_chk++;
            if (rd_en_o !== exp_rd(c) || done_o !== (c == 57) || busy_o !== (c <= 56)) begin
                n_fail++;
                $display("FAIL restart_ignored c=%0d got rd=%b done=%b busy=%b want rd=%b done=%b busy=%b",
                         c, rd_en_o, done_o, busy_o, exp_rd(c), c == 57, c <= 56);
            end
        end
        start_i = 1'b0;
        n_chk++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_err got %b want 0", err_o);
        end
    endtask

    task automatic test_err_flag();
        @(posedge clk_i); #1;
        start_i = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            supp    = 1'b0;
            n_chk++;
            if (err_o !== (c >= 39)) begin
                n_fail++;
                $display("FAIL err_sticky c=%0d got %b want %b", c, err_o, c >= 39);
            end
            n_chk++;
            if (rd_en_o !== exp_rd(c) || done_o !== (c == 57)) begin
                n_fail++;
                $display("FAIL err_sched c=%0d got rd=%b done=%b want rd=%b done=%b",
                         c, rd_en_o, done_o, exp_rd(c), c == 57);
            end
            if (c == 38) supp = 1'b1;
        end
        start_i = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            n_chk++;
            if (err_o !== 1'b0 || rd_en_o !== exp_rd(c) || done_o !== (c == 57)) begin
                n_fail++;
                $display("FAIL err_clear c=%0d got err=%b rd=%b done=%b want err=0 rd=%b done=%b",
                         c, err_o, rd_en_o, done_o, exp_rd(c), c == 57);
            end
        end
    endtask

    task automatic test_reset_abort();
        @(posedge clk_i); #1;
        start_i = 1'b1;
        for (int c = 1; c <= 95; c++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            rst_i   = 1'b0;
            if (c <= 30) begin
                n_chk++;
                if (rd_en_o !== exp_rd(c) || done_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_pre c=%0d got rd=%b done=%b want rd=%b done=0",
                             c, rd_en_o, done_o, exp_rd(c));
                end
            end else if (c <= 35) begin
                n_chk++;
                if ({busy_o, done_o, rd_en_o, bf_en_o, wr_en_o, err_o, stage_o,
                     rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o} !== '0) begin
                    n_fail++;
                    $display("FAIL abort_zero c=%0d got busy=%b done=%b rd=%b bf=%b wr=%b err=%b want all 0",
                             c, busy_o, done_o, rd_en_o, bf_en_o, wr_en_o, err_o);
                end
            end else begin
                n_chk++;
                if (rd_en_o !== exp_rd(c - 35) || wr_en_o !== exp_rd(c - 41) ||
                    done_o !== (c == 92) || busy_o !== (c <= 91)) begin
                    n_fail++;
                    $display("FAIL abort_rerun c=%0d got rd=%b wr=%b done=%b busy=%b want rd=%b wr=%b done=%b busy=%b",
                             c, rd_en_o, wr_en_o, done_o, busy_o,
                             exp_rd(c - 35), exp_rd(c - 41), c == 92, c <= 91);
                end
            end
            if (c == 30) rst_i = 1'b1;
            if (c == 35) start_i = 1'b1;
        end
        n_chk++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_err got %b want 0", err_o);
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_i   = 1'b1;
        start_i = 1'b0;
        supp    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        test_reset();
        test_schedule();
        test_start_ignored();
        test_err_flag();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
